// File: rtl/mf_acc_reader.sv
// Reads one accumulator snapshot from the mixer array and streams it as a
// framed word sequence: header, then I/Q pairs for every enabled frequency.
module mf_acc_reader #(
    parameter int FREQ_NUM = 6,
    parameter int CHANNEL  = 8
) (
    input  logic                             clk_2,
    input  logic                             rst,
    input  logic                             start,
    input  logic [FREQ_NUM-1:0]              freq_mask,
    input  logic [FREQ_NUM-1:0]              mf_err,
    output logic                             mf_iq_read,
    input  logic [32*CHANNEL*FREQ_NUM-1:0]   mf_ipcm_acc,
    input  logic [32*CHANNEL*FREQ_NUM-1:0]   mf_qpcm_acc,
    output logic [31:0]                      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             start_lost
);

    localparam int MW = (FREQ_NUM > 1) ? $clog2(FREQ_NUM) : 1;
    localparam int JW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SNAP   = 3'd1,
        S_LOAD   = 3'd2,
        S_HEAD   = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    state_t              r_state;
    logic [FREQ_NUM-1:0] r_mask;
    logic [MW-1:0]       r_m;
    logic [JW-1:0]       r_j;
    logic                r_q;
    logic                r_armed;
    logic [31:0]         r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_iq_read;
    logic                r_start_lost;

    logic                w_found;
    logic [MW-1:0]       w_nxt_m;
    logic [MW-1:0]       w_m;
    logic [JW-1:0]       w_j;
    logic                w_q;
    logic                w_last;
    logic [31:0]         w_word;
    logic [7:0]          w_err8;
    logic [7:0]          w_mask8;

    // Lowest enabled frequency: from 0 when leaving the header, else above the current one.
    always_comb begin
        w_found = 1'b0;
        w_nxt_m = '0;
        for (int i = FREQ_NUM - 1; i >= 0; i--) begin
            if (r_mask[i] && ((r_state == S_HEAD) || (i > int'(r_m)))) begin
                w_found = 1'b1;
                w_nxt_m = MW'(i);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Position of the word following the one currently presented.
    always_comb begin
        w_m    = r_m;
        w_j    = r_j;
        w_q    = r_q;
        w_last = 1'b0;
        if (r_state == S_HEAD) begin
            w_m = w_nxt_m;
            w_j = '0;
            w_q = 1'b0;
        end else if (!r_q) begin
            w_q    = 1'b1;
            w_last = (r_j == J_LAST) && !w_found;
        end else if (r_j != J_LAST) begin
            w_j = r_j + JW'(1);
            w_q = 1'b0;
        end else begin
            w_m = w_nxt_m;
            w_j = '0;
            w_q = 1'b0;
        end
    end

    // Snapshot word selection and header field widening.
    always_comb begin
        w_word  = 32'd0;
        w_err8  = 8'd0;
        w_mask8 = 8'd0;
        for (int m = 0; m < FREQ_NUM; m++) begin
            w_err8[m]  = mf_err[m];
            w_mask8[m] = r_mask[m];
            for (int j = 0; j < CHANNEL; j++) begin
                if ((w_m == MW'(m)) && (w_j == JW'(j))) begin
                    w_word = w_q ? mf_qpcm_acc[32*(m*CHANNEL+j) +: 32]
                                 : mf_ipcm_acc[32*(m*CHANNEL+j) +: 32];
                end else begin
                    w_word = w_word;
                end
            end
        end
    end

    // Frame sequencer; outputs only move on a handshake so stalls hold everything.
    always_ff @(posedge clk_2 or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_m          <= '0;
            r_j          <= '0;
            r_q          <= 1'b0;
            r_armed      <= 1'b0;
            r_data       <= 32'd0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_iq_read    <= 1'b0;
            r_start_lost <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (start && (r_state != S_IDLE)) begin
                r_start_lost <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && r_armed) begin
                        r_mask    <= freq_mask;
                        r_m       <= '0;
                        r_j       <= '0;
                        r_q       <= 1'b0;
                        r_busy    <= 1'b1;
                        r_iq_read <= 1'b1;
                        r_state   <= S_SNAP;
                    end
                end
                S_SNAP: begin
                    r_iq_read <= 1'b0;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    r_data  <= {16'hA55A, w_err8, w_mask8};
                    r_last  <= (r_mask == '0);
                    r_valid <= 1'b1;
                    r_state <= S_HEAD;
                end
                S_HEAD, S_STREAM: begin
                    if (r_valid && out_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_data  <= 32'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_m     <= w_m;
                            r_j     <= w_j;
                            r_q     <= w_q;
                            r_data  <= w_word;
                            r_last  <= w_last;
                            r_state <= S_STREAM;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mf_iq_read = r_iq_read;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_last   = r_last;
    assign busy       = r_busy;
    assign start_lost = r_start_lost;

endmodule

// File: tb/tb_mf_acc_reader.sv
// Directed bench for mf_acc_reader: table of frames plus hand-written
// sequences for reset release, mid-frame abort and late start pulses.
module tb_mf_acc_reader;

    localparam int FN = 6;
    localparam int CH = 8;

    logic                   clk_2 = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [FN-1:0]          freq_mask = '0;
    logic [FN-1:0]          mf_err = '0;
    logic                   mf_iq_read;
    logic [32*CH*FN-1:0]    mf_ipcm_acc;
    logic [32*CH*FN-1:0]    mf_qpcm_acc;
    logic [31:0]            out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   out_last;
    logic                   busy;
    logic                   start_lost;

    int n_checks = 0;
    int n_errors = 0;
    bit lost_model = 1'b0;

    mf_acc_reader #(.FREQ_NUM(FN), .CHANNEL(CH)) dut (
        .clk_2       (clk_2),
        .rst         (rst),
        .start       (start),
        .freq_mask   (freq_mask),
        .mf_err      (mf_err),
        .mf_iq_read  (mf_iq_read),
        .mf_ipcm_acc (mf_ipcm_acc),
        .mf_qpcm_acc (mf_qpcm_acc),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .start_lost  (start_lost)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [5:0]  mask;
        logic [5:0]  err;
        bit          rnd_ready;
        bit          chg_mask;
        bit          inj_start;
        int          exp_len;
        logic [31:0] exp_hdr;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] i_word(input int m, input int j);
        return {8'hC1, 8'(m), 8'(j), 8'h5A};
    endfunction

    function automatic logic [31:0] q_word(input int m, input int j);
        return {8'hD2, 8'(j), 8'(m), 8'hA5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic run_frame(input logic [5:0] mask, input logic [5:0] err, input bit rnd,
                             input bit chg, input bit inj, input int exp_len,
                             input logic [31:0] exp_hdr);
        logic [31:0] exp_q[$];
        int          cnt;
        int          cyc;
        bit          stalled;
        bit          injected;
        logic [31:0] prev_data;
        logic        prev_last;

        exp_q.delete();
        exp_q.push_back(exp_hdr);
        for (int m = 0; m < FN; m++) begin
            if (mask[m]) begin
                for (int j = 0; j < CH; j++) begin
                    exp_q.push_back(i_word(m, j));
                    exp_q.push_back(q_word(m, j));
                end
            end
        end
        chk("frame_model_len", 32'(exp_q.size()), 32'(exp_len));

        freq_mask = mask;
        mf_err    = err;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (chg) freq_mask = ~mask;
        chk("snap_strobe_c1", 32'(mf_iq_read), 32'd1);
        chk("busy_c1", 32'(busy), 32'd1);
        tick();
        chk("snap_strobe_c2", 32'(mf_iq_read), 32'd0);
        chk("valid_c2", 32'(out_valid), 32'd0);
        tick();
        chk("header_valid_c3", 32'(out_valid), 32'd1);

        cnt = 0;
        cyc = 0;
        stalled = 1'b0;
        injected = 1'b0;
        prev_data = 32'd0;
        prev_last = 1'b0;
        while ((cnt < exp_len) && (cyc < 2000)) begin
            start = 1'b0;
            if (inj && !injected && (cnt == 5)) begin
                start = 1'b1;
                injected = 1'b1;
                lost_model = 1'b1;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk("stall_data_hold", out_data, prev_data);
                chk("stall_last_hold", 32'(out_last), 32'(prev_last));
                chk("stall_valid_hold", 32'(out_valid), 32'd1);
            end
            chk("no_extra_snapshot", 32'(mf_iq_read), 32'd0);
            if (out_valid && out_ready) begin
                chk($sformatf("word_%0d", cnt), out_data, exp_q[cnt]);
                chk($sformatf("last_%0d", cnt), 32'(out_last), 32'(cnt == exp_len - 1));
                cnt++;
            end
            stalled = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("frame_word_count", 32'(cnt), 32'(exp_len));
        chk("valid_after_frame", 32'(out_valid), 32'd0);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("start_lost_flag", 32'(start_lost), 32'(lost_model));
        tick();
    endtask

    initial begin
        int cnt;
        int cyc;

        vecs[0] = '{6'b000101, 6'b000000, 1'b0, 1'b0, 1'b0, 33, 32'hA55A0005};
        vecs[1] = '{6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0,  1, 32'hA55A2000};
        vecs[2] = '{6'b111111, 6'b000000, 1'b1, 1'b0, 1'b0, 97, 32'hA55A003F};
        vecs[3] = '{6'b001001, 6'b010100, 1'b0, 1'b1, 1'b0, 33, 32'hA55A1409};
        vecs[4] = '{6'b100000, 6'b000011, 1'b1, 1'b0, 1'b1, 17, 32'hA55A0320};
        vecs[5] = '{6'b010010, 6'b000000, 1'b0, 1'b0, 1'b0, 33, 32'hA55A0012};

        for (int m = 0; m < FN; m++) begin
            for (int j = 0; j < CH; j++) begin
                mf_ipcm_acc[32*(m*CH+j) +: 32] = i_word(m, j);
                mf_qpcm_acc[32*(m*CH+j) +: 32] = q_word(m, j);
            end
        end

        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_iq_read", 32'(mf_iq_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start_lost", 32'(start_lost), 32'd0);

        tick();
        rst = 1'b1;
        start = 1'b1;
        freq_mask = 6'b000101;
        tick();
        start = 1'b0;
        chk("start_too_soon_ignored", 32'(mf_iq_read), 32'd0);
        chk("start_too_soon_busy", 32'(busy), 32'd0);
        tick();

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].mask, vecs[v].err, vecs[v].rnd_ready, vecs[v].chg_mask,
                      vecs[v].inj_start, vecs[v].exp_len, vecs[v].exp_hdr);
        end

        freq_mask = 6'b111111;
        mf_err = 6'b000000;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        cyc = 0;
        while ((cnt < 9) && (cyc < 200)) begin
            if (out_valid && out_ready) cnt++;
            tick();
            cyc++;
        end
        chk("abort_reached_word10", 32'(cnt), 32'd9);
        chk("abort_word10_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", out_data, 32'd0);
        chk("abort_lost_clr", 32'(start_lost), 32'd0);
        lost_model = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_words", 32'(out_valid), 32'd0);
        end
        rst = 1'b1;
        tick();
        tick();
        chk("post_abort_valid", 32'(out_valid), 32'd0);
        run_frame(6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0, 17, 32'hA55A0002);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mf_acc_reader.md
MF_ACC_READER -- requirements
Module: mf_acc_reader

Interface
REQ-001 Parameter FREQ_NUM, default 6, number of mixing frequencies; legal range 1..8.
REQ-002 Parameter CHANNEL, default 8, number of AD channels per frequency; legal range 1..16.
REQ-003 clk_2  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to read out one accumulation snapshot.
REQ-006 freq_mask  input  FREQ_NUM  bit m set = include frequency m in the readout; sampled at accepted start.
REQ-007 mf_err  input  FREQ_NUM  per-frequency sticky error flags from the mixer array.
REQ-008 mf_iq_read  output  1  one-cycle snapshot strobe to the mixer array.
REQ-009 mf_ipcm_acc  input  32*CHANNEL*FREQ_NUM  I snapshot; word (m,j) at bits 32*(m*CHANNEL+j)+31:32*(m*CHANNEL+j).
REQ-010 mf_qpcm_acc  input  32*CHANNEL*FREQ_NUM  Q snapshot; same layout as mf_ipcm_acc.
REQ-011 out_data  output  32  stream word.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-014 out_last  output  1  marks the final word of a frame; qualified by out_valid.
REQ-015 busy  output  1  high from accepted start until the frame completes.
REQ-016 start_lost  output  1  sticky flag: start arrived while busy; cleared only by reset.

Function
REQ-017 The state machine SHALL have states IDLE, SNAP, LOAD, HEAD, STREAM.
REQ-018 In IDLE, start=1 SHALL latch freq_mask and move to SNAP; busy SHALL go high the next cycle.
REQ-019 SNAP SHALL assert mf_iq_read for exactly one cycle, then move to LOAD.
REQ-020 LOAD SHALL last exactly one cycle so the registered snapshot settles, then move to HEAD.
REQ-021 Latency: start at cycle 0 -> mf_iq_read at cycle 1 -> header out_valid at cycle 3.
REQ-022 In HEAD, out_data SHALL be {16'hA55A, 8'(mf_err zero-extended), 8'(latched mask zero-extended)}, with mf_err sampled on HEAD entry.
REQ-023 After the header, STREAM SHALL emit, for each m ascending with mask bit set and each j ascending 0..CHANNEL-1, the I word (m,j) followed by the Q word (m,j).
REQ-024 Frame length SHALL be 1 + 2*CHANNEL*popcount(mask) words.
REQ-025 out_last SHALL be high on the final word only: the Q word of the highest enabled (m, CHANNEL-1), or the header if the mask is zero.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_last and the state SHALL hold unchanged.
REQ-027 The word index SHALL advance only on handshake; disabled frequencies SHALL be skipped with no idle cycles between words.
REQ-028 On handshake of the last word, the block SHALL return to IDLE; busy and out_valid SHALL fall the next cycle.
REQ-029 The earliest next start SHALL be accepted in the IDLE cycle after the frame ends.
REQ-030 A start seen in any state other than IDLE SHALL be ignored and SHALL set start_lost.
REQ-031 mf_iq_read SHALL never be asserted outside SNAP, so the snapshot stays stable for the whole frame.
REQ-032 Changes to freq_mask after start is accepted SHALL have no effect on the current frame.

Reset
REQ-033 With rst low, the block SHALL immediately enter IDLE with out_valid=0, out_last=0, out_data=0, mf_iq_read=0, busy=0, start_lost=0, and the latched mask and indices at 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no further words; after release the block SHALL accept a new start normally.
REQ-035 The first start SHALL be honoured only on a clock edge at least one cycle after rst is released.

Verification
REQ-036 FREQ_NUM=6, CHANNEL=8, mask=6'b000101, out_ready=1 held, mf_err=0 -> mf_iq_read at cycle 1; 33 words: header 0xA55A0005, then I/Q for m=0 j=0..7, then m=2 j=0..7; out_last on the 33rd word only.
REQ-037 Mask=0, mf_err=6'b100000 -> a single word 0xA55A2000 with out_last=1; busy drops the following cycle.
REQ-038 Mask=6'b111111 with out_ready toggling pseudo-randomly -> 97 words in correct order; no word duplicated or dropped; data stable during every stall.
REQ-039 start pulsed again during STREAM -> frame unaffected, start_lost=1, no second mf_iq_read.
REQ-040 rst pulled low on the 10th word, then released, then start with mask=6'b000010 -> no words after the abort; the new frame is 17 words with header 0xA55A0002.
REQ-041 freq_mask changed one cycle after start -> frame content follows the originally latched mask.
